// File: rtl/lcd_cmd_pkg.sv
// Shared types and constants for the character-LCD command engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP    = 3'd0,
        ST_INIT_CMD = 3'd1,
        ST_SETUP    = 3'd2,
        ST_PULSE    = 3'd3,
        ST_HOLD     = 3'd4,
        ST_WAIT     = 3'd5,
        ST_IDLE     = 3'd6
    } state_t;

    // HD44780 power-up sequence: 8-bit/2-line, display on, clear, entry mode.
    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR    = 8'h01;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;
    localparam logic [1:0] INIT_LAST     = 2'd3;

    // Status word bit positions.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_INIT    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_FUNC_SET;
            2'd1:    return INIT_DISP_ON;
            2'd2:    return INIT_CLEAR;
            default: return INIT_ENTRY;
        endcase
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; flushed by reset.
// Latency: push visible in count/empty one cycle later; head read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; no same-cycle bypass.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_ctrl.sv
// HD44780 command engine: buffers LSU writes, runs power-up init, drives EN/RS/data timing.
// Latency: push->pop 1 cycle; EN rises 1+T_SETUP cycles after pop, command occupies 1+T_SETUP+T_PULSE+T_HOLD+wait.
// Backpressure: o_wr_ready low when FIFO full; writes while full are dropped and set sticky overflow.
module lcd_cmd_ctrl
    import lcd_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int T_PWRUP    = 750000,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 12,
    parameter int T_HOLD     = 2,
    parameter int T_EXEC     = 2000,
    parameter int T_CLEAR    = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wr_valid,
    input  logic [8:0]  i_wr_data,
    input  logic        i_ovf_clr,
    output logic        o_wr_ready,
    output logic [31:0] o_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on
);

    localparam int M0    = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
    localparam int M1    = (T_EXEC > T_PULSE) ? T_EXEC : T_PULSE;
    localparam int M2    = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int M3    = (M1 > M2) ? M1 : M2;
    localparam int T_MAX = (M0 > M3) ? M0 : M3;
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_done;
    logic [1:0]       init_idx;
    logic [1:0]       init_idx_nxt;
    logic             init_done;
    logic             init_done_nxt;
    logic [7:0]       data_nxt;
    logic             rs_nxt;
    logic             en_nxt;
    logic             overflow;
    logic             busy;

    logic             fifo_pop;
    logic [8:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset_n),
        .push      (i_wr_valid),
        .push_data (i_wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cnt_done   = (cnt == '0);
    assign o_wr_ready = !fifo_full;
    assign o_lcd_rw   = 1'b0;
    assign busy       = !init_done || !fifo_empty || (state != ST_IDLE);

    // Status word seen by LSU loads from the LCD address.
    always_comb begin
        o_status                                = '0;
        o_status[STAT_BUSY]                     = busy;
        o_status[STAT_INIT]                     = init_done;
        o_status[STAT_OVF]                      = overflow;
        o_status[STAT_CNT_LSB +: 4]             = 4'(fifo_count);
    end

    // Next-state, counter reload and output-register next values.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_done ? cnt : cnt - CNT_W'(1);
        init_idx_nxt  = init_idx;
        init_done_nxt = init_done;
        data_nxt      = o_lcd_data;
        rs_nxt        = o_lcd_rs;
        en_nxt        = 1'b0;
        fifo_pop      = 1'b0;
        case (state)
            ST_PWRUP: begin
                if (cnt_done) begin
                    state_nxt = ST_INIT_CMD;
                    cnt_nxt   = '0;
                end
            end
            ST_INIT_CMD: begin
                state_nxt = ST_SETUP;
                data_nxt  = init_cmd(init_idx);
                rs_nxt    = 1'b0;
                cnt_nxt   = CNT_W'(T_SETUP - 1);
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    state_nxt = ST_PULSE;
                    en_nxt    = 1'b1;
                    cnt_nxt   = CNT_W'(T_PULSE - 1);
                end
            end
            ST_PULSE: begin
                en_nxt = 1'b1;
                if (cnt_done) begin
                    state_nxt = ST_HOLD;
                    en_nxt    = 1'b0;
                    cnt_nxt   = CNT_W'(T_HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = is_clear_home(o_lcd_rs, o_lcd_data) ?
                                CNT_W'(T_CLEAR - 1) : CNT_W'(T_EXEC - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    cnt_nxt = '0;
                    if (init_done) begin
                        state_nxt = ST_IDLE;
                    end else if (init_idx == INIT_LAST) begin
                        init_done_nxt = 1'b1;
                        state_nxt     = ST_IDLE;
                    end else begin
                        init_idx_nxt = init_idx + 2'd1;
                        state_nxt    = ST_INIT_CMD;
                    end
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    data_nxt  = fifo_head[7:0];
                    rs_nxt    = fifo_head[8];
                    state_nxt = ST_SETUP;
                    // The pop cycle is folded into SETUP, so it runs one extra cycle.
                    cnt_nxt   = CNT_W'(T_SETUP);
                end
            end
            default: begin
                state_nxt = ST_PWRUP;
                cnt_nxt   = CNT_W'(T_PWRUP - 1);
            end
        endcase
    end

    // FSM state, timing counter and init progress.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_PWRUP;
            cnt       <= CNT_W'(T_PWRUP - 1);
            init_idx  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_idx  <= init_idx_nxt;
            init_done <= init_done_nxt;
        end
    end

    // Registered LCD pins; EN drops immediately on reset assertion.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_lcd_data <= '0;
            o_lcd_rs   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_on   <= 1'b0;
        end else begin
            o_lcd_data <= data_nxt;
            o_lcd_rs   <= rs_nxt;
            o_lcd_en   <= en_nxt;
            o_lcd_on   <= 1'b1;
        end
    end

    // Sticky overflow: a dropped write wins over a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow <= 1'b0;
        end else if (i_wr_valid && fifo_full) begin
            overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Directed bench for lcd_cmd_ctrl with short timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic [8:0]  wr_data;
    logic        ovf_clr;
    logic        wr_ready;
    logic [31:0] status;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_cmd_ctrl #(
        .FIFO_DEPTH (4),
        .T_PWRUP    (20),
        .T_SETUP    (1),
        .T_PULSE    (3),
        .T_HOLD     (1),
        .T_EXEC     (5),
        .T_CLEAR    (10)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_wr_valid (wr_valid),
        .i_wr_data  (wr_data),
        .i_ovf_clr  (ovf_clr),
        .o_wr_ready (wr_ready),
        .o_status   (status),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One EN strobe: lead time to rise, payload, pulse width, hold payload,
    // then low cycles until the next rise or until busy clears.
    task automatic pulse(input string tag, input logic [7:0] d, input logic rs,
                         input int exp_lead, input int exp_gap);
        int lead = 0;
        int high = 0;
        int gap  = 0;
        while (!lcd_en && lead < 400) begin
            tick();
            lead++;
        end
        if (exp_lead >= 0) check({tag, " lead"}, 32'(lead), 32'(exp_lead));
        check({tag, " en_rise"}, {31'd0, lcd_en}, 32'd1);
        check({tag, " payload"}, {23'd0, lcd_rs, lcd_data}, {23'd0, rs, d});
        while (lcd_en && high < 50) begin
            tick();
            high++;
        end
        check({tag, " en_width"}, 32'(high), 32'd3);
        check({tag, " hold_payload"}, {23'd0, lcd_rs, lcd_data}, {23'd0, rs, d});
        while (!lcd_en && status[0] && gap < 400) begin
            tick();
            gap++;
        end
        check({tag, " gap"}, 32'(gap), 32'(exp_gap));
    endtask

    logic [8:0] words [6];

    initial begin
        int n;
        words[0] = 9'h148;
        words[1] = 9'h045;
        words[2] = 9'h14C;
        words[3] = 9'h04C;
        words[4] = 9'h14F;
        words[5] = 9'h150;

        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        ovf_clr  = 1'b0;
        #12;
        check("rst status", status, 32'h1);
        check("rst pins", {28'd0, lcd_rs, lcd_rw, lcd_en, lcd_on}, 32'd0);
        check("rst data", {24'd0, lcd_data}, 32'd0);
        check("rst ready", {31'd0, wr_ready}, 32'd1);

        // Power-up and init sequence.
        reset_n = 1'b1;
        tick();
        check("lcd_on", {31'd0, lcd_on}, 32'd1);
        check("pwrup status", status, 32'h1);
        pulse("init0", 8'h38, 1'b0, 21, 8);
        pulse("init1", 8'h0C, 1'b0, -1, 8);
        pulse("init2", 8'h01, 1'b0, -1, 13);
        pulse("init3", 8'h06, 1'b0, -1, 6);
        check("init done status", status, 32'h2);

        // Single data write after init.
        wr_valid = 1'b1;
        wr_data  = 9'h141;
        tick();
        wr_valid = 1'b0;
        check("push count", status, 32'h13);
        pulse("data41", 8'h41, 1'b1, 3, 6);
        check("idle after data", status, 32'h2);

        // Clear (long wait) followed by a data write of the same byte.
        wr_valid = 1'b1;
        wr_data  = 9'h001;
        tick();
        wr_data  = 9'h101;
        tick();
        wr_valid = 1'b0;
        check("two push status", status, 32'h13);
        pulse("clear", 8'h01, 1'b0, 2, 14);
        pulse("data01", 8'h01, 1'b1, -1, 6);
        check("idle after pair", status, 32'h2);

        // Reset in the middle of an EN pulse.
        wr_valid = 1'b1;
        wr_data  = 9'h141;
        tick();
        wr_data  = 9'h145;
        tick();
        wr_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 50) begin
            tick();
            n++;
        end
        check("pre-reset en", {31'd0, lcd_en}, 32'd1);
        check("pre-reset count", {28'd0, status[7:4]}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid-reset en", {31'd0, lcd_en}, 32'd0);
        check("mid-reset status", status, 32'h1);
        check("mid-reset on", {31'd0, lcd_on}, 32'd0);
        check("mid-reset ready", {31'd0, wr_ready}, 32'd1);
        reset_n = 1'b1;
        tick();
        check("re-on", {31'd0, lcd_on}, 32'd1);

        // Six back-to-back writes during power-up: four fit, two overflow.
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = words[i];
            tick();
        end
        wr_valid = 1'b0;
        check("full ready", {31'd0, wr_ready}, 32'd0);
        check("full status", status, 32'h45);
        pulse("reinit0", 8'h38, 1'b0, 15, 8);
        pulse("reinit1", 8'h0C, 1'b0, -1, 8);
        pulse("reinit2", 8'h01, 1'b0, -1, 13);
        pulse("reinit3", 8'h06, 1'b0, -1, 9);
        pulse("q0", 8'h48, 1'b1, -1, 9);
        pulse("q1", 8'h45, 1'b0, -1, 9);
        pulse("q2", 8'h4C, 1'b1, -1, 9);
        pulse("q3", 8'h4C, 1'b0, -1, 6);
        check("drained status", status, 32'h6);

        // Overflow clear, then clear coincident with a dropped write.
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf cleared", status, 32'h2);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 9'h120 + 9'(i);
            ovf_clr  = (i == 5);
            tick();
        end
        wr_valid = 1'b0;
        ovf_clr  = 1'b0;
        check("ovf vs clr status", status, 32'h47);
        check("ovf vs clr ready", {31'd0, wr_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_ctrl.md
# lcd_cmd_ctrl

Character-LCD command engine on the memory-mapped IO path, directly downstream of the load/store unit's LCD register. Accepts RS/data command words written by the LSU, buffers them in a small FIFO, runs the HD44780 power-up init sequence, and generates the EN strobe and bus timing on the LCD pins. Exposes a status word that the LSU returns on loads from the LCD address, so software polls `busy` instead of bit-banging.

## Interface
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- T_PWRUP, 750000, cycles waited after reset before the first init command (15 ms @ 50 MHz)
- T_SETUP, 2, cycles RS/data are stable before EN rises
- T_PULSE, 12, cycles EN is high
- T_HOLD, 2, cycles RS/data are held after EN falls
- T_EXEC, 2000, post-strobe wait for normal commands and data
- T_CLEAR, 82000, post-strobe wait for clear/home (RS=0, data 0x01..0x03)

- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_wr_valid  in  1  one-cycle write strobe from LSU (store to LCD address)
- i_wr_data  in  9  bit 8 = RS, bits 7:0 = LCD data/command
- i_ovf_clr  in  1  clears sticky overflow flag
- o_wr_ready  out  1  FIFO not full
- o_status  out  32  bit0 busy, bit1 init_done, bit2 overflow, bits 7:4 FIFO count, rest 0
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write, tied 0 (write only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power enable

## Operation
- Reset values: o_lcd_data 0, o_lcd_rs 0, o_lcd_rw 0, o_lcd_en 0, o_lcd_on 0, o_wr_ready 1, overflow 0, init_done 0, FIFO empty, state PWRUP; busy reads 1.
- o_lcd_on goes 1 on the first clock edge after reset release and stays 1.
- Push: i_wr_valid with count < FIFO_DEPTH at that edge → entry written. If full → write dropped, overflow set. No same-cycle bypass: a pop on a full FIFO does not admit a concurrent push.
- Overflow is sticky. i_ovf_clr clears it; a clear and a new overflow on the same cycle leave it set.
- States: PWRUP → INIT_CMD → SETUP → PULSE → HOLD → WAIT → (INIT_CMD | IDLE); IDLE → SETUP on pop.
- PWRUP: count T_PWRUP cycles, then INIT_CMD.
- Init sequence, RS=0: 0x38, 0x0C, 0x01, 0x06, each through SETUP/PULSE/HOLD/WAIT. After the WAIT of 0x06, init_done=1 and the FSM enters IDLE.
- Writes during init are accepted into the FIFO and execute after init.
- IDLE with FIFO non-empty: pop head, latch RS/data into output registers, enter SETUP.
- SETUP: T_SETUP cycles with EN=0. PULSE: T_PULSE cycles with EN=1. HOLD: T_HOLD cycles with EN=0. RS and data are stable for the whole span.
- WAIT length: T_CLEAR if RS=0 and data ∈ {0x01,0x02,0x03}; otherwise T_EXEC. Outputs hold their last values.
- busy = !init_done | FIFO non-empty | state ≠ IDLE.
- Reset asserted mid-operation: EN drops asynchronously, FIFO is flushed, all flags are cleared, and the full init sequence reruns after release.

## Timing
- Push at edge t: count is visible at t+1. If IDLE, the pop happens at edge t+1 and SETUP starts at t+2.
- EN rises exactly T_SETUP cycles after SETUP entry and stays high exactly T_PULSE cycles.
- Per-command occupancy from pop: 1 + T_SETUP + T_PULSE + T_HOLD + wait cycles, then IDLE. The next pop happens at the earliest on the following edge.
- All outputs are registered; o_status and o_wr_ready are combinational from registers only.
- Counters are sized $clog2(max parameter + 1) and reload on every state entry.

## Structure
- lcd_cmd_pkg: state enum, init command constants (0x38, 0x0C, 0x01, 0x06), status bit positions, clear/home decode function.
- Sub-module lcd_cmd_fifo: synchronous FIFO (push/pop/full/empty/count), same clock and reset. The top holds the FSM, timing counter and output registers.

## Test plan
Parameters for all scenarios: T_PWRUP=20, T_SETUP=1, T_PULSE=3, T_HOLD=1, T_EXEC=5, T_CLEAR=10.
- Reset release → four EN pulses of 3 cycles carrying 0x38, 0x0C, 0x01, 0x06 with RS=0; the gap after 0x01 is 10 wait cycles, the others 5; status bit1 then reads 1 and bit0 reads 0.
- After init, push 0x141 → RS=1, data 0x41 stable from SETUP through HOLD; EN high 3 cycles starting 3 cycles after the push edge; busy returns to 0 after 11 cycles from pop.
- During PWRUP, push 6 words back-to-back → 4 accepted, o_wr_ready low, overflow=1, count=4; after init the 4 accepted words drain in order.
- Push 0x001 (RS=0) and then 0x101 (RS=1) → waits of 10 and 5 cycles respectively.
- Assert i_reset_n low during PULSE → EN 0 in the same cycle, FIFO count 0, init_done 0; after release the init sequence restarts from PWRUP.
- Set overflow, then pulse i_ovf_clr → bit2 reads 0; clear coincident with a dropped push → bit2 stays 1.
